// File: rtl/if_stage_hazard_pkg.sv
// Pipeline definitions shared by the fetch stage and its hazard unit:
// opcodes, the canonical nop and instruction field positions.
package if_stage_hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    // Instructions that read rt as a source register.
    function automatic logic op_uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/if_stage_hazard_hazard_detect.sv
// Load-use hazard detection: the instruction in ID reads the register a load
// in EX is about to write.
module hazard_detect
    import if_stage_hazard_pkg::*;
(
    input  logic [OP_MSB:RT_LSB] id_instr_hi,
    input  logic                 id_valid,
    input  logic                 ex_MemRead,
    input  logic [4:0]           ex_rt,
    output logic                 load_use
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;

    assign op = id_instr_hi[OP_MSB:OP_LSB];
    assign rs = id_instr_hi[RS_MSB:RS_LSB];
    assign rt = id_instr_hi[RT_MSB:RT_LSB];

    // $0 is never a real dependency.
    assign load_use = id_valid && ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == rs) || (op_uses_rt(op) && (ex_rt == rt)));

endmodule

// File: rtl/if_stage_hazard.sv
// Fetch stage: PC register, IF/ID pipeline register, load-use stall and
// branch redirect, plus saturating stall/flush counters.
module if_stage_hazard
    import if_stage_hazard_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [31:0]          imem_addr,
    input  logic [31:0]          imem_rdata,
    input  logic                 ex_MemRead,
    input  logic [4:0]           ex_rt,
    input  logic                 mem_PCSrc,
    input  logic [31:0]          mem_branch_target,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc_plus4,
    output logic                 id_valid,
    output logic                 bubble_id_ex,
    output logic                 flush_ex_mem,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic        load_use;

    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;

    hazard_detect u_hazard_detect (
        .id_instr_hi (id_instr[OP_MSB:RT_LSB]),
        .id_valid    (id_valid),
        .ex_MemRead  (ex_MemRead),
        .ex_rt       (ex_rt),
        .load_use    (load_use)
    );

    assign bubble_id_ex = load_use | mem_PCSrc;
    assign flush_ex_mem = mem_PCSrc;

    // A taken branch wins over a stall: the stalled instruction is squashed anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
            stall_count <= '0;
            flush_count <= '0;
        end else if (mem_PCSrc) begin
            pc_q        <= mem_branch_target;
            id_instr    <= NOP_INSTR;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
            if (flush_count != CNT_MAX) begin
                flush_count <= flush_count + CNT_WIDTH'(1);
            end
        end else if (load_use) begin
            if (stall_count != CNT_MAX) begin
                stall_count <= stall_count + CNT_WIDTH'(1);
            end
        end else begin
            pc_q        <= pc_plus4;
            id_instr    <= imem_rdata;
            id_pc_plus4 <= pc_plus4;
            id_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage_hazard.sv
// Self-checking bench for if_stage_hazard: directed cases with literal
// expectations, then randomized traffic against a behavioural pipeline model.
module tb_if_stage_hazard;
    import if_stage_hazard_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        ex_MemRead;
    logic [4:0]  ex_rt;
    logic        mem_PCSrc;
    logic [31:0] mem_branch_target;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        bubble_id_ex;
    logic        flush_ex_mem;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    logic [31:0] mem [0:63];

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [15:0] m_stall;
    logic [15:0] m_flush;

    if_stage_hazard #(
        .RESET_PC  (32'h0000_0000),
        .CNT_WIDTH (16)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_addr         (imem_addr),
        .imem_rdata        (imem_rdata),
        .ex_MemRead        (ex_MemRead),
        .ex_rt             (ex_rt),
        .mem_PCSrc         (mem_PCSrc),
        .mem_branch_target (mem_branch_target),
        .id_instr          (id_instr),
        .id_pc_plus4       (id_pc_plus4),
        .id_valid          (id_valid),
        .bubble_id_ex      (bubble_id_ex),
        .flush_ex_mem      (flush_ex_mem),
        .stall_count       (stall_count),
        .flush_count       (flush_count)
    );

    assign imem_rdata = mem[imem_addr[7:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_lu();
        int  op;
        int  rs;
        int  rt;
        bit  uses;
        op   = int'(m_instr >> 26);
        rs   = int'((m_instr >> 21) & 32'h1f);
        rt   = int'((m_instr >> 16) & 32'h1f);
        uses = (op == 0) || (op == 'h2B) || (op == 'h04);
        return m_valid && ex_MemRead && (int'(ex_rt) != 0) &&
               ((int'(ex_rt) == rs) || (uses && (int'(ex_rt) == rt)));
    endfunction

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_stall = 16'h0;
        m_flush = 16'h0;
    endtask

    task automatic check_all();
        cmp("imem_addr", imem_addr, m_pc);
        cmp("id_instr", id_instr, m_instr);
        cmp("id_pc_plus4", id_pc_plus4, m_pc4);
        cmp("id_valid", 32'(id_valid), 32'(m_valid));
        cmp("bubble_id_ex", 32'(bubble_id_ex), 32'(model_lu() | mem_PCSrc));
        cmp("flush_ex_mem", 32'(flush_ex_mem), 32'(mem_PCSrc));
        cmp("stall_count", 32'(stall_count), 32'(m_stall));
        cmp("flush_count", 32'(flush_count), 32'(m_flush));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge.
    task automatic tick();
        logic lu;
        lu = model_lu();
        @(posedge clk);
        if (mem_PCSrc) begin
            m_pc    = mem_branch_target;
            m_instr = 32'h0;
            m_pc4   = 32'h0;
            m_valid = 1'b0;
            if (m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
        end else if (lu) begin
            if (m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        end else begin
            m_instr = mem[m_pc[7:2]];
            m_pc4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        #2;
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    task automatic clear_inputs();
        ex_MemRead        = 1'b0;
        ex_rt             = 5'd0;
        mem_PCSrc         = 1'b0;
        mem_branch_target = 32'h0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [5];
        ops[0] = OP_RTYPE;
        ops[1] = OP_SW;
        ops[2] = OP_BEQ;
        ops[3] = OP_LW;
        ops[4] = 6'h08;
        return {ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 16'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = NOP_INSTR;
        mem[0]  = 32'h2008_0001;
        mem[1]  = 32'h2009_0002;
        mem[2]  = 32'h0109_5020;
        mem[3]  = 32'h2109_0005;
        mem[63] = 32'h0109_5020;
        clear_inputs();
        model_reset();
        rst_n = 1'b0;

        // Reset state
        #3;
        check_all();
        cmp("reset imem_addr", imem_addr, 32'h0);
        cmp("reset id_valid", 32'(id_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        settle_check();

        // Straight-line fetch
        tick();
        settle_check();
        cmp("fetch1 id_pc_plus4", id_pc_plus4, 32'h4);
        cmp("fetch1 id_instr", id_instr, 32'h2008_0001);
        tick();
        settle_check();
        cmp("fetch2 id_pc_plus4", id_pc_plus4, 32'h8);
        cmp("fetch2 id_instr", id_instr, 32'h2009_0002);
        cmp("fetch2 imem_addr", imem_addr, 32'h8);

        // Load-use on rs of an R-type add
        tick();
        ex_MemRead = 1'b1;
        ex_rt      = 5'd8;
        settle_check();
        cmp("lu bubble", 32'(bubble_id_ex), 32'h1);
        tick();
        settle_check();
        cmp("lu pc held", imem_addr, 32'hC);
        cmp("lu instr held", id_instr, 32'h0109_5020);
        cmp("lu stall_count", 32'(stall_count), 32'h1);
        ex_rt = 5'd0;
        settle_check();
        cmp("lu rt0 bubble", 32'(bubble_id_ex), 32'h0);
        tick();
        settle_check();

        // addi does not read rt
        ex_rt = 5'd9;
        settle_check();
        cmp("addi rt bubble", 32'(bubble_id_ex), 32'h0);
        ex_rt = 5'd8;
        settle_check();
        cmp("addi rs bubble", 32'(bubble_id_ex), 32'h1);

        // Branch beats a simultaneous load-use
        mem_PCSrc         = 1'b1;
        mem_branch_target = 32'h40;
        settle_check();
        cmp("br bubble", 32'(bubble_id_ex), 32'h1);
        cmp("br flush_ex_mem", 32'(flush_ex_mem), 32'h1);
        tick();
        clear_inputs();
        settle_check();
        cmp("br pc", imem_addr, 32'h40);
        cmp("br id_valid", 32'(id_valid), 32'h0);
        cmp("br flush_count", 32'(flush_count), 32'h1);
        cmp("br stall_count", 32'(stall_count), 32'h1);

        // PC wrap
        mem_PCSrc         = 1'b1;
        mem_branch_target = 32'hFFFF_FFFC;
        settle_check();
        tick();
        clear_inputs();
        settle_check();
        cmp("wrap pc top", imem_addr, 32'hFFFF_FFFC);
        tick();
        settle_check();
        cmp("wrap pc", imem_addr, 32'h0);
        cmp("wrap pc_plus4", id_pc_plus4, 32'h0);

        // Stall counter saturation
        ex_MemRead = 1'b1;
        ex_rt      = 5'd8;
        settle_check();
        for (int i = 0; i < 65539; i++) begin
            tick();
            settle_check();
        end
        cmp("sat stall_count", 32'(stall_count), 32'hFFFF);
        cmp("sat pc held", imem_addr, 32'h0);

        // Asynchronous reset in the middle of a stall
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cmp("mid rst imem_addr", imem_addr, 32'h0);
        cmp("mid rst stall_count", 32'(stall_count), 32'h0);
        cmp("mid rst bubble", 32'(bubble_id_ex), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_inputs();

        // Randomized traffic
        for (int i = 0; i < 64; i++) mem[i] = rand_instr();
        for (int n = 0; n < 3000; n++) begin
            ex_MemRead = 1'($urandom_range(0, 1));
            ex_rt      = 5'($urandom_range(0, 3));
            mem_PCSrc  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) mem_branch_target = $urandom;
            else mem_branch_target = {24'h0, 6'($urandom), 2'b00};
            settle_check();
            if (n == 1500) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        settle_check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
